// File: rtl/dti_tmr_scrub_pkg.sv
// Shared types and helpers for the TMR background scrubber.
package dti_tmr_scrub_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RWAIT,
    VOTE,
    WR,
    NEXT,
    DONE,
    WAIT
  } scrub_state_e;

  // Increment enable for a saturating counter: bump only when not already at max.
  function automatic logic sat_inc_en(input logic inc, input logic at_max);
    return inc & ~at_max;
  endfunction

endpackage

// File: rtl/dti_tmr_vote_w.sv
// Word-wide 2-of-3 majority voter with per-copy disagreement flags.
module dti_tmr_vote_w #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  input  logic [DW-1:0] d2,
  output logic [DW-1:0] v,
  output logic          m0,
  output logic          m1,
  output logic          m2
);

  assign v  = (d0 & d1) | (d1 & d2) | (d0 & d2);
  assign m0 = (d0 != v);
  assign m1 = (d1 != v);
  assign m2 = (d2 != v);

endmodule

// File: rtl/dti_tmr_scrub_ctrl.sv
// Background scrubber: reads all three copies of each entry, votes, and
// writes the voted word back when any copy disagrees.
module dti_tmr_scrub_ctrl
  import dti_tmr_scrub_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 8,
  parameter int DEPTH  = 256,
  parameter int CNT_W  = 16,
  parameter int INTV_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic [INTV_W-1:0] interval,
  output logic              rd_req,
  output logic [AW-1:0]     rd_addr,
  input  logic              rd_gnt,
  input  logic              rd_vld,
  input  logic [DW-1:0]     rd_d0,
  input  logic [DW-1:0]     rd_d1,
  input  logic [DW-1:0]     rd_d2,
  output logic              wr_req,
  output logic [AW-1:0]     wr_addr,
  output logic [DW-1:0]     wr_data,
  input  logic              wr_gnt,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_cnt0,
  output logic [CNT_W-1:0]  err_cnt1,
  output logic [CNT_W-1:0]  err_cnt2,
  output logic              multi_err,
  input  logic              err_clr
);

  scrub_state_e      state, state_nxt;
  logic [AW-1:0]     addr;
  logic [INTV_W-1:0] wait_cnt;
  logic [DW-1:0]     d0_q, d1_q, d2_q;
  logic [DW-1:0]     voted;
  logic              m0, m1, m2;
  logic              last_entry;

  dti_tmr_vote_w #(.DW(DW)) u_vote (
    .d0 (d0_q),
    .d1 (d1_q),
    .d2 (d2_q),
    .v  (voted),
    .m0 (m0),
    .m1 (m1),
    .m2 (m2)
  );

  assign last_entry = (addr == AW'(DEPTH - 1));
  assign rd_addr    = addr;
  assign wr_addr    = addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start && en) state_nxt = RD;
      end
      RD: begin
        rd_req = 1'b1;
        if (rd_gnt) state_nxt = RWAIT;
      end
      RWAIT: begin
        if (rd_vld) state_nxt = VOTE;
      end
      VOTE: begin
        state_nxt = (m0 | m1 | m2) ? WR : NEXT;
      end
      WR: begin
        wr_req = 1'b1;
        if (wr_gnt) state_nxt = NEXT;
      end
      NEXT: begin
        if (!en)            state_nxt = IDLE;
        else if (last_entry) state_nxt = DONE;
        else                state_nxt = RD;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = (interval != '0) ? WAIT : IDLE;
      end
      WAIT: begin
        busy = 1'b0;
        // Leaving at a count of 2 lands RD exactly 'interval' cycles after DONE.
        if (!en)                          state_nxt = IDLE;
        else if (wait_cnt <= INTV_W'(2))  state_nxt = RD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr     <= '0;
      wait_cnt <= '0;
      d0_q     <= '0;
      d1_q     <= '0;
      d2_q     <= '0;
      wr_data  <= '0;
    end else begin
      case (state)
        RWAIT: begin
          if (rd_vld) begin
            d0_q <= rd_d0;
            d1_q <= rd_d1;
            d2_q <= rd_d2;
          end
        end
        VOTE: wr_data <= voted;
        NEXT: begin
          if (!en)              addr <= '0;
          else if (!last_entry) addr <= addr + AW'(1);
        end
        DONE: begin
          addr     <= '0;
          wait_cnt <= interval;
        end
        WAIT: wait_cnt <= wait_cnt - INTV_W'(1);
        default: ;
      endcase
    end
  end

  // Error statistics; a clear in the vote cycle takes priority over the update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt0  <= '0;
      err_cnt1  <= '0;
      err_cnt2  <= '0;
      multi_err <= 1'b0;
    end else if (err_clr) begin
      err_cnt0  <= '0;
      err_cnt1  <= '0;
      err_cnt2  <= '0;
      multi_err <= 1'b0;
    end else if (state == VOTE) begin
      err_cnt0  <= err_cnt0 + CNT_W'(sat_inc_en(m0, &err_cnt0));
      err_cnt1  <= err_cnt1 + CNT_W'(sat_inc_en(m1, &err_cnt1));
      err_cnt2  <= err_cnt2 + CNT_W'(sat_inc_en(m2, &err_cnt2));
      multi_err <= multi_err | (m0 & m1 & m2);
    end
  end

endmodule

// File: doc/dti_tmr_scrub_ctrl.md
Name: dti_tmr_scrub_ctrl

Overview:
- Background scrubber for a triplicated (TMR) register file / SRAM bank.
- Walks every address, reads all three copies, and forms the bitwise 2-of-3 majority (same function as the TMR voter cell).
- On any disagreement, writes the voted word back to all three copies.
- Keeps per-copy error statistics and sits beside the functional port arbiter as a low-priority requester.

Parameters:
- DW, 32: data word width per copy
- AW, 8: address width
- DEPTH, 256: number of entries scrubbed per pass (≤ 2**AW)
- CNT_W, 16: width of per-copy error counters
- INTV_W, 16: width of the inter-pass interval counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- en  in  1  scrubber enable; 0 = stop after current entry
- start  in  1  one-cycle pulse, starts a pass from IDLE
- interval  in  INTV_W  cycles between auto passes; 0 = manual (start only)
- rd_req  out  1  read request to arbiter
- rd_addr  out  AW  read address
- rd_gnt  in  1  read grant
- rd_vld  in  1  read data valid
- rd_d0, rd_d1, rd_d2  in  DW  copy 0/1/2 read data
- wr_req  out  1  write-back request
- wr_addr  out  AW  write address
- wr_data  out  DW  voted word, written to all copies
- wr_gnt  in  1  write grant
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at pass completion
- err_cnt0, err_cnt1, err_cnt2  out  CNT_W  per-copy mismatch counters
- multi_err  out  1  sticky: voted word matched no copy
- err_clr  in  1  synchronous clear of counters and multi_err

Behaviour:
- Reset (async, rst=1): state IDLE, address 0, interval counter 0. rd_req, wr_req, busy, done, multi_err = 0; all err_cnt = 0; rd_addr, wr_addr, wr_data = 0. Reset mid-pass abandons the pending request with no write-back.
- States:
  - IDLE: start & en -> RD.
  - RD: rd_req=1, rd_addr=addr stable; rd_gnt -> RWAIT.
  - RWAIT: rd_req=0; rd_vld -> VOTE. Latch d0..d2 on rd_vld.
  - VOTE (1 cycle): v = (d0&d1)|(d1&d2)|(d0&d2); m_i = (d_i != v). Any m_i -> WR, else NEXT.
  - WR: wr_req=1, wr_addr=addr, wr_data=v held stable; wr_gnt -> NEXT.
  - NEXT: if !en -> IDLE (abort, no done, addr reset to 0); elif addr==DEPTH-1 -> DONE; else addr+1 -> RD.
  - DONE (1 cycle): done=1, addr=0. interval!=0 -> WAIT (load count=interval), else IDLE.
  - WAIT: count down each cycle; !en -> IDLE; count reaches 1 -> RD. start is ignored in WAIT.
- busy=1 in every state except IDLE and WAIT.
- Grant rules: a grant in the same cycle the request rises is accepted. rd_vld arrives ≥1 cycle after rd_gnt; rd_vld outside RWAIT is ignored. No timeout.
- Statistics, updated in the VOTE cycle:
  - err_cnt_i += m_i, saturating at 2**CNT_W-1.
  - multi_err set when m0&m1&m2.
  - err_clr wins over a simultaneous increment or set.
- start while busy is ignored. en low in IDLE blocks start.
- Throughput: clean entry with zero-wait grants = 4 cycles (RD, RWAIT, VOTE, NEXT). Write-back adds ≥1 cycle (WR).

Decomposition:
- Package dti_tmr_scrub_pkg: state enum (IDLE, RD, RWAIT, VOTE, WR, NEXT, DONE, WAIT) and a saturating-increment function.
- Sub-module dti_tmr_vote_w: DW-wide bitwise majority plus the three mismatch flags, combinational. The controller is the only sequential logic.

Test Plan:
1. DEPTH=4, all copies equal 0xA5A5A5A5, zero-wait grants, start -> 4 reads, no wr_req, done pulse at cycle 16±1, err_cnt all 0.
2. Addr 2: d1=0xA5A5A5A4 -> one write, wr_addr=2, wr_data=0xA5A5A5A5; err_cnt1=1, others 0, multi_err=0.
3. Addr 1: d0=0x1, d1=0x2, d2=0x4 -> v=0x0, write 0x0; all counters +1; multi_err=1 until err_clr.
4. rd_gnt delayed 5 cycles and wr_gnt delayed 3 cycles -> rd_addr, wr_addr and wr_data stable throughout, exactly one transaction each.
5. en dropped during WR of addr 1 -> write completes, then IDLE, no done, busy=0. A new start begins at addr 0.
6. Counter preset to 0xFFFF plus another mismatch -> stays 0xFFFF. err_clr in the same VOTE cycle -> counter 0.
7. interval=10 -> second pass's first rd_req exactly 10 cycles after done. rst asserted mid-RWAIT -> all outputs 0 immediately.
